// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receive path.
package ps2_pkg;

   localparam int PS2_DATA_BITS  = 8;
   localparam int PS2_FRAME_BITS = 11;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } ps2_rx_state_t;

endpackage

// File: rtl/edge_detector.sv
// Registered previous-level edge detector.
module edge_detector #(
   parameter logic RESET_LEVEL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic fall,
   output logic rise
);

   logic prev;

   always_ff @(posedge clk) begin
      if (rst) prev <= RESET_LEVEL;
      else     prev <= din;
   end

   assign fall = prev & ~din;
   assign rise = ~prev & din;

endmodule

// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host frame receiver: start, 8 data LSB-first,
// odd parity, stop; one byte strobe or error pulse per frame.
module ps2_rx_frame
   import ps2_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk_db,
   input  logic       ps2_data_db,
   output logic [7:0] data,
   output logic       data_valid,
   output logic       parity_err,
   output logic       frame_err
);

   localparam int TW = $clog2(TIMEOUT_CYCLES);
   localparam int BW = $clog2(PS2_DATA_BITS);
   localparam logic [TW-1:0] T_ONE  = TW'(1);
   // Decided one cycle early so the registered pulse lands on
   // exactly TIMEOUT_CYCLES after the last edge.
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 2);
   localparam logic [BW-1:0] B_LAST = BW'(PS2_DATA_BITS - 1);

   ps2_rx_state_t state_q, state_d;

   logic [PS2_DATA_BITS-1:0] shreg_q, shreg_d;
   logic [BW-1:0]            bcnt_q, bcnt_d;
   logic [TW-1:0]            tcnt_q, tcnt_d;
   logic                     par_ok_q, par_ok_d;
   logic [7:0]               data_d;
   logic                     dv_d, pe_d, fe_d;
   logic                     fall;

   edge_detector #(.RESET_LEVEL(1'b1)) u_clk_edge (
      .clk  (clk),
      .rst  (rst),
      .din  (ps2_clk_db),
      .fall (fall),
      .rise ()
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         shreg_q    <= '0;
         bcnt_q     <= '0;
         tcnt_q     <= '0;
         par_ok_q   <= 1'b0;
         data       <= 8'h00;
         data_valid <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         state_q    <= state_d;
         shreg_q    <= shreg_d;
         bcnt_q     <= bcnt_d;
         tcnt_q     <= tcnt_d;
         par_ok_q   <= par_ok_d;
         data       <= data_d;
         data_valid <= dv_d;
         parity_err <= pe_d;
         frame_err  <= fe_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      shreg_d  = shreg_q;
      bcnt_d   = bcnt_q;
      tcnt_d   = '0;
      par_ok_d = par_ok_q;
      data_d   = data;
      dv_d     = 1'b0;
      pe_d     = 1'b0;
      fe_d     = 1'b0;

      if (state_q != ST_IDLE && !fall)
         tcnt_d = tcnt_q + T_ONE;

      unique case (state_q)
         ST_IDLE: begin
            if (fall && !ps2_data_db) begin
               state_d = ST_DATA;
               bcnt_d  = '0;
            end
         end
         ST_DATA: begin
            if (fall) begin
               shreg_d = {ps2_data_db, shreg_q[7:1]};
               bcnt_d  = bcnt_q + BW'(1);
               if (bcnt_q == B_LAST)
                  state_d = ST_PARITY;
            end
         end
         ST_PARITY: begin
            if (fall) begin
               par_ok_d = ^{shreg_q, ps2_data_db};
               state_d  = ST_STOP;
            end
         end
         ST_STOP: begin
            if (fall) begin
               state_d = ST_IDLE;
               if (ps2_data_db && par_ok_q) begin
                  data_d = shreg_q;
                  dv_d   = 1'b1;
               end else if (ps2_data_db) begin
                  pe_d = 1'b1;
               end else begin
                  fe_d = 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // An edge on the terminal count wins over the timeout.
      if (state_q != ST_IDLE && !fall && tcnt_q == T_LAST) begin
         state_d = ST_IDLE;
         tcnt_d  = '0;
         fe_d    = 1'b1;
      end
   end

endmodule

// File: tb/tb_ps2_rx_frame.sv
// Directed bench for ps2_rx_frame with a 50-cycle timeout.
module tb_ps2_rx_frame;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ps2_clk_db = 1'b1;
   logic       ps2_data_db = 1'b1;
   logic [7:0] data;
   logic       data_valid;
   logic       parity_err;
   logic       frame_err;

   int n_chk = 0;
   int n_pass = 0;
   int cyc = 0;
   int fall_cyc = 0;
   int dv_cyc = -1;
   int fe_cyc = -1;
   int n_dv = 0, n_pe = 0, n_fe = 0, n_multi = 0;
   logic [7:0] dv_log[$];
   int s_dv, s_pe, s_fe;

   ps2_rx_frame #(.TIMEOUT_CYCLES(50)) dut (
      .clk         (clk),
      .rst         (rst),
      .ps2_clk_db  (ps2_clk_db),
      .ps2_data_db (ps2_data_db),
      .data        (data),
      .data_valid  (data_valid),
      .parity_err  (parity_err),
      .frame_err   (frame_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (data_valid) begin
         n_dv++;
         dv_cyc = cyc;
         dv_log.push_back(data);
      end
      if (parity_err) n_pe++;
      if (frame_err) begin
         n_fe++;
         fe_cyc = cyc;
      end
      if (int'(data_valid) + int'(parity_err) + int'(frame_err) > 1)
         n_multi++;
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic logic [10:0] mkframe(input logic [7:0] b,
                                           input logic flip,
                                           input logic stop);
      return {stop, (~^b) ^ flip, b, 1'b0};
   endfunction

   task automatic send_bit(input logic b, input int hi, input int lo);
      @(negedge clk);
      ps2_data_db = b;
      repeat (hi) @(negedge clk);
      ps2_clk_db = 1'b0;
      fall_cyc = cyc;
      repeat (lo) @(negedge clk);
      ps2_clk_db = 1'b1;
   endtask

   task automatic send_bits(input logic [10:0] f, input int n,
                            input int hi, input int lo);
      for (int i = 0; i < n; i++) send_bit(f[i], hi, lo);
      @(negedge clk);
      ps2_data_db = 1'b1;
   endtask

   task automatic snap();
      s_dv = n_dv;
      s_pe = n_pe;
      s_fe = n_fe;
   endtask

   initial begin
      repeat (4) @(negedge clk);
      chk("rst_data", 32'(data), 32'h00);
      chk("rst_dv", 32'(data_valid), 0);
      chk("rst_pe", 32'(parity_err), 0);
      chk("rst_fe", 32'(frame_err), 0);
      rst = 1'b0;
      repeat (4) @(negedge clk);

      // good 8'h1C, 40-cycle edge spacing
      snap();
      send_bits(mkframe(8'h1C, 1'b0, 1'b1), 11, 20, 20);
      repeat (5) @(negedge clk);
      chk("1c_data", 32'(data), 32'h1C);
      chk("1c_dv_cnt", 32'(n_dv - s_dv), 1);
      chk("1c_dv_lat", 32'(dv_cyc - fall_cyc), 1);
      chk("1c_err", 32'(n_pe - s_pe + n_fe - s_fe), 0);

      // bad parity
      snap();
      send_bits(mkframe(8'hF0, 1'b1, 1'b1), 11, 20, 20);
      repeat (5) @(negedge clk);
      chk("par_pe", 32'(n_pe - s_pe), 1);
      chk("par_dv", 32'(n_dv - s_dv), 0);
      chk("par_data", 32'(data), 32'h1C);

      // stop bit 0, then good 8'h5A
      snap();
      send_bits(mkframe(8'h33, 1'b0, 1'b0), 11, 20, 20);
      repeat (5) @(negedge clk);
      chk("stop_fe", 32'(n_fe - s_fe), 1);
      chk("stop_pe_dv", 32'(n_pe - s_pe + n_dv - s_dv), 0);
      chk("stop_data", 32'(data), 32'h1C);
      send_bits(mkframe(8'h5A, 1'b0, 1'b1), 11, 20, 20);
      repeat (5) @(negedge clk);
      chk("5a_data", 32'(data), 32'h5A);

      // timeout after 4 data bits
      snap();
      send_bits(mkframe(8'hA5, 1'b0, 1'b1), 5, 20, 20);
      repeat (70) @(negedge clk);
      chk("to_fe", 32'(n_fe - s_fe), 1);
      chk("to_lat", 32'(fe_cyc - fall_cyc), 50);
      chk("to_dv", 32'(n_dv - s_dv), 0);
      snap();
      send_bits(mkframe(8'h29, 1'b0, 1'b1), 11, 20, 20);
      repeat (5) @(negedge clk);
      chk("29_data", 32'(data), 32'h29);
      chk("29_dv", 32'(n_dv - s_dv), 1);
      chk("29_fe", 32'(n_fe - s_fe), 0);

      // reset after 5 data bits
      snap();
      send_bits(mkframe(8'h77, 1'b0, 1'b1), 6, 20, 20);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("mrst_data", 32'(data), 32'h00);
      chk("mrst_pulses",
          32'({data_valid, parity_err, frame_err}), 0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (60) @(negedge clk);
      chk("mrst_quiet",
          32'(n_dv - s_dv + n_pe - s_pe + n_fe - s_fe), 0);
      send_bits(mkframe(8'hE0, 1'b0, 1'b1), 11, 20, 20);
      repeat (5) @(negedge clk);
      chk("e0_data", 32'(data), 32'hE0);
      chk("e0_dv", 32'(n_dv - s_dv), 1);
      chk("e0_err", 32'(n_pe - s_pe + n_fe - s_fe), 0);

      // spurious edge, then tight back-to-back 8'h12 / 8'h34
      snap();
      dv_log.delete();
      send_bit(1'b1, 3, 3);
      repeat (5) @(negedge clk);
      chk("spur_err", 32'(n_pe - s_pe + n_fe - s_fe), 0);
      send_bits(mkframe(8'h12, 1'b0, 1'b1), 11, 2, 2);
      send_bits(mkframe(8'h34, 1'b0, 1'b1), 11, 1, 1);
      repeat (5) @(negedge clk);
      chk("b2b_dv", 32'(n_dv - s_dv), 2);
      chk("b2b_err", 32'(n_pe - s_pe + n_fe - s_fe), 0);
      if (dv_log.size() == 2) begin
         chk("b2b_first", 32'(dv_log[0]), 32'h12);
         chk("b2b_second", 32'(dv_log[1]), 32'h34);
      end else begin
         chk("b2b_log", 32'(dv_log.size()), 2);
      end
      chk("b2b_data", 32'(data), 32'h34);

      chk("one_hot", 32'(n_multi), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
